// File: rtl/cpu_bus_sequencer.sv
// cpu_bus_sequencer: FIFO-buffered bus master that replays queued commands as
// 6801-style multiplexed AS/E/RW bus cycles. P4 carries address[15:8]; P3
// carries address[7:0] during setup/latch and write data during turn/data.
// Optional feature macro: SEQ_READBACK_EN. When defined, read commands sample
// P3_IN at the end of the data phase. When undefined, every command is a write
// and no read-capture logic is built.
module cpu_bus_sequencer #(
  parameter int DEPTH      = 4,
  parameter int PHASE_CLKS = 1
) (
  input  logic        XTAL_IN,
  input  logic        RESET_IN,
  input  logic        CMD_VALID_IN,
  output logic        CMD_READY_OUT,
  input  logic        CMD_RW_IN,
  input  logic [15:0] CMD_ADDR_IN,
  input  logic [7:0]  CMD_DATA_IN,
  output logic        RD_VALID_OUT,
  output logic [7:0]  RD_DATA_OUT,
  output logic        BUSY_OUT,
  output logic        E_OUT,
  output logic        AS_OUT,
  output logic        RW_OUT,
  output logic [7:0]  P4_OUT,
  output logic [7:0]  P3_OUT,
  output logic        P3_OE_OUT,
  input  logic [7:0]  P3_IN
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (PHASE_CLKS > 1) ? $clog2(PHASE_CLKS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PHASE_CLKS - 1);
  localparam logic [PW-1:0] FULL_CNT = PW'(DEPTH);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3} state_t;

  state_t        state;
  logic [CW-1:0] phase_cnt;
  logic          phase_end;

  logic [24:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic          full, empty, push, pop;
  logic          cmd_rw;
  logic          head_rw;
  logic [15:0]   head_addr;
  logic [7:0]    head_data;
  logic          cur_rw;
  logic [7:0]    cur_data;

`ifdef SEQ_READBACK_EN
  assign cmd_rw = CMD_RW_IN;
`else
  // Without readback the direction bit is forced to write and P3_IN is unused.
  logic unused_inputs;
  assign cmd_rw        = 1'b0;
  assign unused_inputs = ^{CMD_RW_IN, P3_IN};
`endif

  assign empty         = (wr_ptr == rd_ptr);
  assign CMD_READY_OUT = !full;
  assign push          = CMD_VALID_IN && !full;
  assign phase_end     = (phase_cnt == LAST_CNT);
  // A new bus cycle starts from IDLE, or straight out of the last T3 clock.
  assign pop           = !empty && ((state == IDLE) || ((state == T3) && phase_end));
  assign wr_nxt        = wr_ptr + PW'(push);
  assign rd_nxt        = rd_ptr + PW'(pop);
  assign BUSY_OUT      = (state != IDLE) || !empty;
  assign {head_rw, head_addr, head_data} = mem[rd_ptr[AW-1:0]];

  // Command storage; contents need no reset since the pointers define validity
  always_ff @(posedge XTAL_IN) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {cmd_rw, CMD_ADDR_IN, CMD_DATA_IN};
    end
  end

  // FIFO pointers and registered full flag (a same-clock pop cannot free a slot)
  always_ff @(posedge XTAL_IN) begin
    if (RESET_IN) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      full   <= ((wr_nxt - rd_nxt) == FULL_CNT);
    end
  end

  // Bus-cycle sequencer: state, phase counter and registered bus pins
  always_ff @(posedge XTAL_IN) begin
    if (RESET_IN) begin
      state     <= IDLE;
      phase_cnt <= '0;
      E_OUT     <= 1'b1;
      AS_OUT    <= 1'b0;
      RW_OUT    <= 1'b1;
      P4_OUT    <= '0;
      P3_OUT    <= '0;
      P3_OE_OUT <= 1'b0;
      cur_rw    <= 1'b0;
    end else if (pop) begin
      state     <= T0;
      phase_cnt <= '0;
      E_OUT     <= 1'b0;
      AS_OUT    <= 1'b0;
      RW_OUT    <= head_rw;
      P4_OUT    <= head_addr[15:8];
      P3_OUT    <= head_addr[7:0];
      P3_OE_OUT <= 1'b1;
      cur_rw    <= head_rw;
      cur_data  <= head_data;
    end else if (state != IDLE) begin
      if (!phase_end) begin
        phase_cnt <= phase_cnt + CW'(1);
      end else begin
        phase_cnt <= '0;
        case (state)
          T0: begin
            state  <= T1;
            AS_OUT <= 1'b1;
          end
          T1: begin
            state  <= T2;
            AS_OUT <= 1'b0;
            if (cur_rw) begin
              P3_OE_OUT <= 1'b0;
            end else begin
              P3_OUT <= cur_data;
            end
          end
          T2: begin
            state <= T3;
            E_OUT <= 1'b1;
          end
          default: begin
            // End of T3 with nothing queued: park the bus, P3/P4 keep their values
            state     <= IDLE;
            E_OUT     <= 1'b1;
            AS_OUT    <= 1'b0;
            RW_OUT    <= 1'b1;
            P3_OE_OUT <= 1'b0;
          end
        endcase
      end
    end
  end

`ifdef SEQ_READBACK_EN
  logic       rd_valid;
  logic [7:0] rd_data;

  // Capture P3_IN on the final clock of a read's data phase; pulse valid once
  always_ff @(posedge XTAL_IN) begin
    if (RESET_IN) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else begin
      rd_valid <= 1'b0;
      if ((state == T3) && phase_end && cur_rw) begin
        rd_valid <= 1'b1;
        rd_data  <= P3_IN;
      end
    end
  end

  assign RD_VALID_OUT = rd_valid;
  assign RD_DATA_OUT  = rd_data;
`else
  assign RD_VALID_OUT = 1'b0;
  assign RD_DATA_OUT  = '0;
`endif

endmodule

// File: tb/tb_cpu_bus_sequencer.sv
// tb_cpu_bus_sequencer: scoreboard bench for cpu_bus_sequencer. Two instances
// (PHASE_CLKS=1 and PHASE_CLKS=3) share one monitor through a select mux; the
// stimulus queues expected commands and the monitor replays each one as the
// ideal AS/E/RW waveform and compares it sample by sample.
module tb_cpu_bus_sequencer;

`ifdef SEQ_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    logic        rw;
    logic [15:0] addr;
    logic [7:0]  data;
  } cmd_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             sel;
  logic [1:0]       valid, rw;
  logic [1:0][15:0] addr;
  logic [1:0][7:0]  data;
  logic [7:0]       p3_in;
  logic [1:0]       ready, rdv, busy, e_o, as_o, rw_o, oe_o;
  logic [1:0][7:0]  rdd, p4_o, p3_o;

  cpu_bus_sequencer #(.DEPTH(4), .PHASE_CLKS(1)) dut_p1 (
    .XTAL_IN(clk), .RESET_IN(rst), .CMD_VALID_IN(valid[0]), .CMD_READY_OUT(ready[0]),
    .CMD_RW_IN(rw[0]), .CMD_ADDR_IN(addr[0]), .CMD_DATA_IN(data[0]),
    .RD_VALID_OUT(rdv[0]), .RD_DATA_OUT(rdd[0]), .BUSY_OUT(busy[0]),
    .E_OUT(e_o[0]), .AS_OUT(as_o[0]), .RW_OUT(rw_o[0]), .P4_OUT(p4_o[0]),
    .P3_OUT(p3_o[0]), .P3_OE_OUT(oe_o[0]), .P3_IN(p3_in));

  cpu_bus_sequencer #(.DEPTH(4), .PHASE_CLKS(3)) dut_p3 (
    .XTAL_IN(clk), .RESET_IN(rst), .CMD_VALID_IN(valid[1]), .CMD_READY_OUT(ready[1]),
    .CMD_RW_IN(rw[1]), .CMD_ADDR_IN(addr[1]), .CMD_DATA_IN(data[1]),
    .RD_VALID_OUT(rdv[1]), .RD_DATA_OUT(rdd[1]), .BUSY_OUT(busy[1]),
    .E_OUT(e_o[1]), .AS_OUT(as_o[1]), .RW_OUT(rw_o[1]), .P4_OUT(p4_o[1]),
    .P3_OUT(p3_o[1]), .P3_OE_OUT(oe_o[1]), .P3_IN(p3_in));

  logic       m_ready, m_rdv, m_busy, m_e, m_as, m_rw, m_oe;
  logic [7:0] m_rdd, m_p4, m_p3;
  int         pcur;
  assign m_ready = ready[sel];
  assign m_rdv   = rdv[sel];
  assign m_busy  = busy[sel];
  assign m_e     = e_o[sel];
  assign m_as    = as_o[sel];
  assign m_rw    = rw_o[sel];
  assign m_oe    = oe_o[sel];
  assign m_rdd   = rdd[sel];
  assign m_p4    = p4_o[sel];
  assign m_p3    = p3_o[sel];
  assign pcur    = sel ? 3 : 1;

  int   checks = 0;
  int   errors = 0;
  cmd_t exp_q[$];
  int   starts[$];
  int   ncyc = 0;
  bit   in_cyc = 0;
  int   idx = 0;
  bit   rd_pend = 0;
  bit   just_end = 0;
  bit   prev_e = 0;
  logic [7:0]  rd_exp = '0;
  int   rdv_count = 0;
  int   rd_done_exp = 0;
  logic [15:0] dev_addr = '0;

  // Peripheral model: the byte a read of address a returns.
  function automatic logic [7:0] rdval(input logic [15:0] a);
    if (a == 16'h1003) return 8'hA5;
    return {a[3:0], a[7:4]} ^ a[15:8] ^ 8'h5A;
  endfunction

  // Peripheral drives the bus while the master has released P3 with E high.
  assign p3_in = (m_e && !m_oe && m_rw && m_busy) ? rdval(dev_addr) : 8'h00;

  // Ideal pins for sample j of a bus cycle: {E, AS, RW, P4, P3, OE}.
  function automatic logic [19:0] exp_sample(input cmd_t c, input int j, input int p);
    int         k;
    logic       oe;
    logic [7:0] p3v;
    k   = j / p;
    oe  = RB ? (!c.rw || (k < 2)) : 1'b1;
    p3v = (k < 2) ? c.addr[7:0] : c.data;
    return {(k == 3), (k == 1), c.rw, c.addr[15:8], p3v, oe};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_reset_vals(input int i);
    check("rst_ready", ready[i], 1);
    check("rst_rd_valid", rdv[i], 0);
    check("rst_rd_data", rdd[i], 0);
    check("rst_busy", busy[i], 0);
    check("rst_e", e_o[i], 1);
    check("rst_as", as_o[i], 0);
    check("rst_rw", rw_o[i], 1);
    check("rst_p4", p4_o[i], 0);
    check("rst_p3", p3_o[i], 0);
    check("rst_p3_oe", oe_o[i], 0);
  endtask

  // Offer one command; called at posedge+1, returns at posedge+1 after acceptance.
  task automatic push(input logic r, input logic [15:0] a, input logic [7:0] d, output int waits);
    cmd_t c;
    logic acc;
    valid[sel] = 1'b1;
    rw[sel]    = r;
    addr[sel]  = a;
    data[sel]  = d;
    waits      = 0;
    acc        = 1'b0;
    while (1) begin
      acc = m_ready;
      @(posedge clk);
      #1;
      if (acc) break;
      waits++;
      if (waits > 300) begin
        check("push_timeout", 1, 0);
        break;
      end
    end
    valid[sel] = 1'b0;
    if (acc) begin
      c.rw   = r & RB;
      c.addr = a;
      c.data = d;
      exp_q.push_back(c);
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((m_busy || in_cyc || rd_pend || exp_q.size() != 0) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_drained"}, (n < 1000), 1);
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check({name, "_busy"}, m_busy, 0);
  endtask

  // Monitor: detects each E falling edge as a cycle start and scores it
  initial begin : monitor
    cmd_t        cur;
    int          nbad;
    logic [19:0] act, ex, msk;
    cur  = '{1'b0, 16'h0, 8'h0};
    nbad = 0;
    forever begin
      @(negedge clk);
      ncyc++;
      if (m_rdv === 1'b1) rdv_count++;
      if (m_as === 1'b1) dev_addr = {m_p4, m_p3};
      if (rst) begin
        in_cyc   = 0;
        rd_pend  = 0;
        just_end = 0;
        exp_q.delete();
      end else begin
        if (rd_pend) begin
          check("rd_valid", m_rdv, 1);
          check("rd_data", m_rdd, rd_exp);
          rd_pend = 0;
        end else if (m_rdv !== 1'b0) begin
          check("rd_valid_spurious", m_rdv, 0);
        end
        if (!in_cyc && prev_e && (m_e === 1'b0)) begin
          if (exp_q.size() == 0) begin
            check("unexpected_cycle", 1, 0);
          end else begin
            cur    = exp_q.pop_front();
            in_cyc = 1;
            idx    = 0;
            nbad   = 0;
            starts.push_back(ncyc);
          end
        end else if (just_end) begin
          check("post_cycle_idle", {m_e, m_as, m_rw, m_oe}, 4'b1010);
        end
        just_end = 0;
        if (in_cyc) begin
          act = {m_e, m_as, m_rw, m_p4, m_p3, m_oe};
          ex  = exp_sample(cur, idx, pcur);
          msk = ex[0] ? 20'hFFFFF : 20'hFFE01;
          if ((act & msk) !== (ex & msk)) begin
            if (nbad == 0)
              $display("  bus sample %0d of addr %h: got %h want %h", idx, cur.addr, act, ex);
            nbad++;
          end
          idx++;
          if (idx == 4 * pcur) begin
            in_cyc   = 0;
            just_end = 1;
            check("bus_cycle", nbad, 0);
            if (cur.rw) begin
              rd_pend = 1;
              rd_exp  = rdval(cur.addr);
              rd_done_exp++;
            end
          end
        end
      end
      prev_e = m_e;
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int         w, pn, n, rdv0, nst;
    int         wts[5];
    logic [7:0] wdat[6];
    wdat  = '{8'h6C, 8'h01, 8'h10, 8'h00, 8'hDF, 8'h7F};
    sel   = 1'b0;
    rst   = 1'b1;
    valid = '0;
    rw    = '0;
    addr  = '0;
    data  = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_reset_vals(0);
    check_reset_vals(1);

    // Six register writes back to back at one clock per phase
    starts.delete();
    pn = ncyc;
    for (int i = 0; i < 6; i++) push(1'b0, 16'(16'h1000 + i), wdat[i], w);
    wait_idle("seq6");
    check("seq6_cycles", starts.size(), 6);
    if (starts.size() == 6) begin
      check("seq6_latency", starts[0] - pn, 3);
      for (int i = 1; i < 6; i++) check("seq6_gap", starts[i] - starts[i-1], 4);
    end
    check("seq6_idle_e", m_e, 1);

    // FIFO fill while one long cycle executes
    sel = 1'b1;
    starts.delete();
    push(1'b0, 16'($urandom), 8'($urandom), w);
    n = 0;
    while (starts.size() == 0 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("fill_first_started", starts.size(), 1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 5; i++) begin
      push(1'b0, 16'($urandom), 8'($urandom), wts[i]);
      if (i == 2) check("fill_ready_at_3", m_ready, 1);
      if (i == 3) check("fill_ready_at_4", m_ready, 0);
    end
    check("fill_first4_nowait", wts[0] + wts[1] + wts[2] + wts[3], 0);
    check("fill_5th_waited", (wts[4] > 0), 1);
    wait_idle("fill");
    check("fill_cycles", starts.size(), 6);

    // Single write with three clocks per phase
    starts.delete();
    push(1'b0, 16'hBEEF, 8'h42, w);
    wait_idle("phase3");
    check("phase3_cycles", starts.size(), 1);

    // Read of 0x1003 (a write when readback is not built)
    sel  = 1'b0;
    rdv0 = rdv_count;
    push(1'b1, 16'h1003, 8'h3C, w);
    wait_idle("rd1003");
    check("rd1003_pulses", rdv_count - rdv0, RB ? 1 : 0);

    // Randomized mixed traffic on both instances
    for (int blk = 0; blk < 2; blk++) begin
      sel = blk[0];
      for (int i = 0; i < 12; i++) begin
        repeat ($urandom_range(0, 5)) begin
          @(posedge clk);
          #1;
        end
        push(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom), w);
      end
      wait_idle("random");
    end

    // Reset asserted during T2 of a queued three-command burst
    sel = 1'b0;
    starts.delete();
    for (int i = 0; i < 3; i++) push(1'b1, 16'(16'h2000 + i), 8'(8'h90 + i), w);
    n = 0;
    while (!(in_cyc && idx == 2 * pcur + 1) && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("abort_reached_t2", (n < 100), 1);
    rst  = 1'b1;
    rdv0 = rdv_count;
    @(posedge clk);
    #1;
    check_reset_vals(0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    nst = starts.size();
    repeat (20) begin
      @(posedge clk);
      #1;
    end
    check("abort_no_cycles", starts.size(), nst);
    check("abort_no_rd_valid", rdv_count - rdv0, 0);
    check("abort_busy", m_busy, 0);
    check("abort_ready", m_ready, 1);

    check("all_consumed", exp_q.size(), 0);
    check("rd_pulses_total", rdv_count, rd_done_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_bus_sequencer.md
# cpu_bus_sequencer

Synthesizable bus master that replaces the hand-written CPU write mock used to drive IC19's multiplexed 6801-style host port. It buffers write/read commands in a parametrised FIFO and replays each one as a full AS/E/RW bus cycle on the P3 (address-low/data) and P4 (address-high) lines. The phase length is configurable, so register-programming sequences run unattended at any bus speed.

## Interface
- DEPTH, 4: command FIFO entries; power of two, at least 2.
- PHASE_CLKS, 1: XTAL_IN clocks per bus phase; at least 1.
- XTAL_IN  in  1  clock; all logic on rising edge.
- RESET_IN  in  1  synchronous, active-high reset.
- CMD_VALID_IN  in  1  command offered.
- CMD_READY_OUT  out  1  FIFO can accept a command.
- CMD_RW_IN  in  1  1 = read, 0 = write.
- CMD_ADDR_IN  in  16  bus address.
- CMD_DATA_IN  in  8  write data; ignored for reads.
- RD_VALID_OUT  out  1  one-clock pulse: RD_DATA_OUT is new.
- RD_DATA_OUT  out  8  last read result.
- BUSY_OUT  out  1  bus cycle in progress or FIFO non-empty.
- E_OUT  out  1  E strobe.
- AS_OUT  out  1  address strobe.
- RW_OUT  out  1  1 = read, 0 = write.
- P4_OUT  out  8  address[15:8].
- P3_OUT  out  8  address[7:0] or write data.
- P3_OE_OUT  out  1  1 = P3_OUT drives the bus.
- P3_IN  in  8  bus data sampled on reads.

## Operation
**FIFO**
- Circular buffer of {rw, addr, data}, DEPTH entries, log2(DEPTH)+1-bit pointers.
- A command is pushed when CMD_VALID_IN and CMD_READY_OUT are both 1.
- CMD_READY_OUT = !full. full is registered, so a same-clock pop does not allow a push at full.
- A pop happens when the FSM leaves IDLE or T3 to start a new cycle.

**FSM states**
- IDLE: E=1, AS=0, RW=1, P3_OE=0. If the FIFO is non-empty, pop and go to T0.
- T0 (setup): E=0, AS=0, RW=cmd.rw, P4=addr[15:8], P3=addr[7:0], P3_OE=1.
- T1 (latch): AS=1; outputs otherwise as T0.
- T2 (turn): AS=0. For a write, P3=data and P3_OE=1. For a read, P3_OE=0.
- T3 (data): E=1; P3/P3_OE as T2. A read samples P3_IN on the last clock of T3.
- After T3: if the FIFO is non-empty, pop and go straight to T0 (back-to-back). Otherwise go to IDLE.

**Phase counter**
- Each state T0–T3 lasts exactly PHASE_CLKS clocks.
- The counter counts 0..PHASE_CLKS-1 and wraps to 0 on each state change.

**Read results**
- RD_DATA_OUT takes the sampled value, and RD_VALID_OUT pulses, on the clock after T3 ends.
- RD_DATA_OUT holds until the next read completes.

**Other rules**
- P4_OUT and P3_OUT hold their last values in IDLE.
- BUSY_OUT = (state != IDLE) | !empty.
- Reset mid-cycle: the next clock forces all outputs to reset values and flushes the FIFO. No RD_VALID_OUT is issued for the aborted cycle.

## Timing
**Reset values**
- E_OUT=1, AS_OUT=0, RW_OUT=1.
- P4_OUT=0, P3_OUT=0, P3_OE_OUT=0.
- CMD_READY_OUT=1, RD_VALID_OUT=0, RD_DATA_OUT=0, BUSY_OUT=0.

**Latency**
- Push at clock N with an empty FIFO and IDLE state: T0 outputs appear at clock N+2 (FIFO write at N+1, pop at N+1, T0 registered at N+2).
- Bus cycle length: 4·PHASE_CLKS clocks.
- Back-to-back cycles have no IDLE gap.
- RD_VALID_OUT asserts 1 clock after the last T3 clock.

## Configuration
- SEQ_READBACK_EN defined: read commands are executed as above.
- SEQ_READBACK_EN undefined:
  - CMD_RW_IN is ignored and every command is a write.
  - RD_VALID_OUT is tied 0 and RD_DATA_OUT is tied 0.
  - No P3_IN sampling logic is built.
  - P3_OE_OUT=1 throughout T0–T3.

## Test plan
- Reset, then push writes 0x1000..0x1005 with data 6C,01,10,00,DF,7F (PHASE_CLKS=1):
  - six contiguous 4-clock cycles, each showing P4=0x10, P3=addr low in T0/T1, P3=data in T2/T3, RW=0.
  - IDLE with E=1 afterwards.
- DEPTH=4: push 5 commands with no gaps while one is executing:
  - CMD_READY_OUT drops at 4 entries;
  - the 5th is accepted only after a pop;
  - all commands execute in order with no loss.
- SEQ_READBACK_EN, read 0x1003 with P3_IN=0xA5 driven during T3:
  - P3_OE_OUT=0 in T2/T3;
  - one RD_VALID_OUT pulse with RD_DATA_OUT=0xA5;
  - RW_OUT=1 throughout.
- PHASE_CLKS=3, single write: each of T0–T3 lasts exactly 3 clocks; total 12 clocks.
- Assert RESET_IN during T2 of a queued 3-command burst:
  - next clock shows reset values;
  - FIFO empty and BUSY_OUT=0;
  - no further bus cycles and no RD_VALID_OUT.
- Build without SEQ_READBACK_EN and push a read command: it executes as a write with RW_OUT=0, and RD_VALID_OUT never asserts.
